instr_fetch: RTL and testbench

//  Fetch-side writer for the 16-bit instruction register. Holds the PC, issues single-word

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: single-word read bus between the fetch unit and instruction memory.
// The fetch unit is the master (issues mem_rd_en/mem_addr); memory is the slave
// (answers with mem_rd_data qualified by mem_rd_valid).
interface instr_fetch_if #(
  parameter int ADDR_W = 10
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rd_data;
  logic              mem_rd_valid;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    input  mem_rd_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    output mem_rd_valid
  );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch-side writer for the 16-bit instruction register.
// Holds the PC, issues one read at a time to instruction memory and pulses load_en
// for one cycle with each fetched word. The control FSM paces fetches with next_req
// and can redirect the PC with branch_en; a redirect while a read is in flight
// marks that read as squashed so its word never reaches the instruction register.
// Optional feature: define FETCH_TIMEOUT_EN to bound the WAIT state to TIMEOUT
// cycles and raise the sticky fetch_err flag when memory fails to answer.
module instr_fetch #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              next_req,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  instr_fetch_if.master     mem,
  output logic [15:0]       instr,
  output logic              load_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              squash;
  logic              squash_nxt;

  // Capture stage: fetched word and its load strobe travel together.
  logic [15:0]       instr_p1;
  logic [15:0]       instr_nxt;
  logic              vld_p1;
  logic              vld_nxt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0]  to_cnt;
  logic [CNT_W-1:0]  to_cnt_nxt;
  logic              err_nxt;
`endif

  // Next-state, PC, squash and capture-stage decisions for the fetch FSM.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    squash_nxt = squash;
    instr_nxt  = instr_p1;
    vld_nxt    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    to_cnt_nxt = '0;
    err_nxt    = fetch_err;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        // The read goes out at the current PC this cycle regardless of a branch;
        // a branch here only means its answer must be thrown away.
        state_nxt = WAIT;
        if (branch_en) begin
          squash_nxt = 1'b1;
        end
      end

      WAIT: begin
        if (mem.mem_rd_valid) begin
          if (squash || branch_en) begin
            // Stale word (redirect earlier, or redirect arriving with the data):
            // drop it and refetch from the new PC.
            squash_nxt = 1'b0;
            state_nxt  = REQ;
          end else begin
            instr_nxt = mem.mem_rd_data;
            vld_nxt   = 1'b1;
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = HOLD;
          end
        end else begin
          if (branch_en) begin
            squash_nxt = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Memory never answered: give up, flag it, leave the PC where it was.
            state_nxt  = IDLE;
            squash_nxt = 1'b0;
            err_nxt    = 1'b1;
          end else begin
            to_cnt_nxt = to_cnt + CNT_W'(1);
          end
`endif
        end
      end

      HOLD: begin
        if (next_req && !stall) begin
          state_nxt = REQ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A redirect overrides any increment. It is ignored in IDLE, and a timeout
    // abort (the only path back to IDLE) keeps the PC unchanged.
    if (branch_en && (state != IDLE) && (state_nxt != IDLE)) begin
      pc_nxt = branch_addr;
    end
  end

  // State, PC, squash flag and capture stage; reset aborts any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= PC_RST;
      squash   <= 1'b0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      squash   <= squash_nxt;
      instr_p1 <= instr_nxt;
      vld_p1   <= vld_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // WAIT-cycle counter (cleared outside WAIT) and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      fetch_err <= err_nxt;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign fetch_err      = 1'b0;
`endif

  // Memory request is a direct decode of REQ, so it lasts exactly one cycle
  // and can never be high in WAIT or HOLD.
  assign mem.mem_rd_en = (state == REQ);
  assign mem.mem_addr  = (state == REQ) ? pc : '0;
  assign busy          = (state == REQ) || (state == WAIT);
  assign instr         = instr_p1;
  assign load_en       = vld_p1;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed/randomized bench for instr_fetch with a latency-programmable
// memory responder and a PC/word reference model.
module tb_instr_fetch;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          next_req = 1'b0;
  logic          stall = 1'b0;
  logic          branch_en = 1'b0;
  logic [AW-1:0] branch_addr = '0;
  logic [15:0]   instr;
  logic          load_en;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_err;

  instr_fetch_if #(.ADDR_W(AW)) mif ();

  instr_fetch #(.ADDR_W(AW), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .next_req    (next_req),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .mem         (mif),
    .instr       (instr),
    .load_en     (load_en),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Memory image and responder: answers each read mem_lat cycles later.
  logic [15:0]   mem_arr [1024];
  int            mem_lat = 1;
  bit            mute = 1'b0;
  int            pend = 0;
  logic [AW-1:0] pend_addr = '0;
  logic          mrv = 1'b0;
  logic [15:0]   mrd = '0;

  assign mif.mem_rd_valid = mrv;
  assign mif.mem_rd_data  = mrd;

  always @(negedge clk) begin
    if (mif.mem_rd_en && !mute) begin
      pend      <= mem_lat;
      pend_addr <= mif.mem_addr;
      mrv       <= 1'b0;
      mrd       <= 16'($urandom);
    end else if (pend == 1) begin
      pend <= 0;
      mrv  <= 1'b1;
      mrd  <= mem_arr[pend_addr];
    end else begin
      if (pend > 1) pend <= pend - 1;
      mrv <= 1'b0;
      mrd <= 16'($urandom);
    end
  end

  // Observed requests and loads, with the cycle they happened in.
  logic [AW-1:0] ra_q [$];
  int            rc_q [$];
  logic [15:0]   lw_q [$];
  int            lc_q [$];
  int            nload = 0;

  always @(negedge clk) begin
    if (mif.mem_rd_en) begin
      ra_q.push_back(mif.mem_addr);
      rc_q.push_back(cyc);
    end
    if (load_en) begin
      lw_q.push_back(instr);
      lc_q.push_back(cyc);
      nload <= nload + 1;
    end
  end

  // Reference model state: where the next fetch must read from.
  logic [AW-1:0] exp_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    ra_q.delete();
    rc_q.delete();
    lw_q.delete();
    lc_q.delete();
  endtask

  function automatic logic [31:0] qa(input int i);
    return (ra_q.size() > i) ? 32'(ra_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qw(input int i);
    return (lw_q.size() > i) ? 32'(lw_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qlat();
    return (lc_q.size() > 0 && rc_q.size() > 0) ? 32'(lc_q[0] - rc_q[0]) : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_load(input string tag);
    int k = 0;
    while (lw_q.size() < 1 && k < 40) begin
      step(1);
      k++;
    end
    chk({tag, "_loadseen"}, 32'(lw_q.size() >= 1), 32'd1);
  endtask

  task automatic finish_fetch(input string tag, input logic [AW-1:0] addr);
    wait_load(tag);
    step(1);
    chk({tag, "_nreq"}, 32'(ra_q.size()), 32'd1);
    chk({tag, "_addr"}, qa(0), 32'(addr));
    chk({tag, "_nload"}, 32'(lw_q.size()), 32'd1);
    chk({tag, "_word"}, qw(0), 32'(mem_arr[addr]));
    chk({tag, "_lat"}, qlat(), 32'(mem_lat + 1));
    exp_pc = addr + AW'(1);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_fetch(input bit from_idle, input string tag);
    clear_q();
    if (from_idle) start = 1'b1;
    else next_req = 1'b1;
    step(1);
    start = 1'b0;
    next_req = 1'b0;
    finish_fetch(tag, exp_pc);
  endtask

  task automatic hold_branch(input logic [AW-1:0] tgt, input string tag);
    branch_en = 1'b1;
    branch_addr = tgt;
    step(1);
    branch_en = 1'b0;
    exp_pc = tgt;
    chk({tag, "_pc"}, 32'(pc), 32'(tgt));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Redirect 'phase' cycles after the request cycle; the in-flight word must vanish.
  task automatic branch_case(input int phase, input int lat, input logic [AW-1:0] tgt,
                             input string tag);
    logic [AW-1:0] old;
    old = exp_pc;
    mem_arr[old] = 16'hDEAD;
    mem_arr[tgt] = 16'(32'h0100 + $urandom_range(0, 255));
    mem_lat = lat;
    clear_q();
    next_req = 1'b1;
    step(1);
    next_req = 1'b0;
    if (phase > 0) step(phase);
    branch_en = 1'b1;
    branch_addr = tgt;
    step(1);
    branch_en = 1'b0;
    wait_load(tag);
    step(1);
    chk({tag, "_nreq"}, 32'(ra_q.size()), 32'd2);
    chk({tag, "_old"}, qa(0), 32'(old));
    chk({tag, "_new"}, qa(1), 32'(tgt));
    chk({tag, "_nload"}, 32'(lw_q.size()), 32'd1);
    chk({tag, "_word"}, qw(0), 32'(mem_arr[tgt]));
    exp_pc = tgt + AW'(1);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    int            n0;
    int            w;
    logic [AW-1:0] tgt;

    for (int i = 0; i < 1024; i++) mem_arr[i] = 16'($urandom);
    mem_arr[0] = 16'hA5C3;

    // Reset state
    reset = 1'b1;
    step(2);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_load", 32'(load_en), 32'd0);
    chk("rst_rden", 32'(mif.mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mif.mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    reset = 1'b0;
    step(1);
    chk("idle_norq", 32'(ra_q.size()), 32'd0);

    // 1-cycle memory, first word from address 0
    mem_lat = 1;
    exp_pc = '0;
    do_fetch(1'b1, "t1");
    chk("t1_instr", 32'(instr), 32'h0000_A5C3);
    start = 1'b1;
    step(2);
    start = 1'b0;
    chk("t1_start_ign", 32'(busy), 32'd0);

    // Three fetches with 2-cycle latency from a fresh reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    exp_pc = '0;
    mem_lat = 2;
    n0 = nload;
    do_fetch(1'b1, "t2a");
    do_fetch(1'b0, "t2b");
    do_fetch(1'b0, "t2c");
    chk("t2_pulses", 32'(nload - n0), 32'd3);

    // Random latencies and HOLD-state redirects
    for (int r = 0; r < 4; r++) begin
      tgt = AW'($urandom);
      hold_branch(tgt, "rnd_br");
      mem_lat = int'($urandom_range(1, 4));
      do_fetch(1'b0, "rnd_f1");
      do_fetch(1'b0, "rnd_f2");
    end

    // Redirect in WAIT (no data yet), in REQ, and in WAIT together with the data
    hold_branch(10'h100, "t3_pre");
    branch_case(1, 3, 10'h040, "t3_wait");
    chk("t3_instr", 32'(instr), 32'(mem_arr[10'h040]));
    branch_case(0, 2, 10'h2A0, "t3_req");
    branch_case(1, 1, 10'h155, "t3_same");

    // PC wrap at the top of the address space, then stall in HOLD
    hold_branch(10'h3FF, "t4_br");
    mem_lat = 1;
    do_fetch(1'b0, "t4_wrap");
    chk("t4_pc0", 32'(pc), 32'd0);
    clear_q();
    stall = 1'b1;
    next_req = 1'b1;
    step(6);
    chk("t4_stall_noreq", 32'(ra_q.size()), 32'd0);
    chk("t4_stall_busy", 32'(busy), 32'd0);
    stall = 1'b0;
    step(1);
    next_req = 1'b0;
    finish_fetch("t4_rel", exp_pc);

    // Reset while a read is outstanding; the late answer must be ignored
    mem_lat = 4;
    clear_q();
    next_req = 1'b1;
    step(1);
    next_req = 1'b0;
    step(1);
    reset = 1'b1;
    #1;
    chk("t5_pc", 32'(pc), 32'd0);
    chk("t5_instr", 32'(instr), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rden", 32'(mif.mem_rd_en), 32'd0);
    chk("t5_addr", 32'(mif.mem_addr), 32'd0);
    chk("t5_load", 32'(load_en), 32'd0);
    step(1);
    reset = 1'b0;
    exp_pc = '0;
    step(6);
    chk("t5_noload", 32'(lw_q.size()), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_instr2", 32'(instr), 32'd0);
    chk("t5_pc2", 32'(pc), 32'd0);

    // Memory never answers
    mute = 1'b1;
    clear_q();
    start = 1'b1;
    step(1);
    start = 1'b0;
    w = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (!busy) break;
      if (!mif.mem_rd_en) w++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("t6_waitcyc", 32'(w), 32'd15);
    chk("t6_err", 32'(fetch_err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
`else
    chk("t6_waitcyc", 32'(w), 32'd40);
    chk("t6_err", 32'(fetch_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
`endif
    chk("t6_noload", 32'(lw_q.size()), 32'd0);
    mute = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
